// File: rtl/bldc_pkg.sv
// Shared types and tables for the BLDC commutator: FSM state encoding,
// sector / fault-code constants and the six-step drive table.
package bldc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DEAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  localparam logic [2:0] SECTOR_NONE = 3'd7;

  localparam logic [1:0] FC_NONE   = 2'd0;
  localparam logic [1:0] FC_DRIVER = 2'd1;
  localparam logic [1:0] FC_HALL   = 2'd2;
  localparam logic [1:0] FC_STALL  = 2'd3;

  // Returns {high[2:0], low[2:0]} with bit order {C,B,A}. Reverse rotation
  // uses the same table with high and low sides swapped.
  function automatic logic [5:0] drive_pattern(input logic [2:0] sec, input logic fwd);
    logic [2:0] h;
    logic [2:0] l;
    case (sec)
      3'd0:    begin h = 3'b100; l = 3'b010; end
      3'd1:    begin h = 3'b001; l = 3'b010; end
      3'd2:    begin h = 3'b001; l = 3'b100; end
      3'd3:    begin h = 3'b010; l = 3'b100; end
      3'd4:    begin h = 3'b010; l = 3'b001; end
      3'd5:    begin h = 3'b100; l = 3'b001; end
      default: begin h = 3'b000; l = 3'b000; end
    endcase
    return fwd ? {h, l} : {l, h};
  endfunction

endpackage

// File: rtl/bldc_commutator_hall_filter.sv
// Hall front end: 2-flop synchroniser, stability filter and sector decode.
// sector_change pulses for one cycle in the cycle the new sector is visible.
module hall_filter
  import bldc_pkg::*;
#(
  parameter int HALL_FILTER = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hall,
  output logic [2:0] sector,
  output logic       sector_change
);

  localparam int CW = $clog2(HALL_FILTER + 1);

  logic [2:0]    hall_s1, hall_s2, hall_last;
  logic [CW-1:0] stable_cnt;
  logic [2:0]    decoded;

  // Decode synced code; table is written in {h1,h2,h3} order.
  always_comb begin
    decoded = SECTOR_NONE;
    case ({hall_s2[0], hall_s2[1], hall_s2[2]})
      3'b101:  decoded = 3'd0;
      3'b100:  decoded = 3'd1;
      3'b110:  decoded = 3'd2;
      3'b010:  decoded = 3'd3;
      3'b011:  decoded = 3'd4;
      3'b001:  decoded = 3'd5;
      default: decoded = SECTOR_NONE;
    endcase
  end

  // Synchronise, count equal cycles, accept once the code has been stable
  // for HALL_FILTER cycles. The counter saturates so a held code is accepted once.
  always_ff @(posedge clk) begin
    if (reset) begin
      hall_s1       <= '0;
      hall_s2       <= '0;
      hall_last     <= '0;
      stable_cnt    <= '0;
      sector        <= SECTOR_NONE;
      sector_change <= 1'b0;
    end else begin
      hall_s1       <= hall;
      hall_s2       <= hall_s1;
      hall_last     <= hall_s2;
      sector_change <= 1'b0;
      if (hall_s2 != hall_last) begin
        stable_cnt <= '0;
      end else begin
        if (stable_cnt != CW'(HALL_FILTER))
          stable_cnt <= stable_cnt + CW'(1);
        if (stable_cnt == CW'(HALL_FILTER - 1) && decoded != sector) begin
          sector        <= decoded;
          sector_change <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/bldc_commutator.sv
// Six-step BLDC commutator: hall-driven sector selection, dead time between
// drive patterns and latched driver / hall / stall faults.
// Optional stall detection is built when STALL_DETECT_EN is defined.
module bldc_commutator
  import bldc_pkg::*;
#(
  parameter int DEAD_TIME    = 64,
  parameter int HALL_FILTER  = 16,
  parameter int STALL_CYCLES = 16_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       dir,
  input  logic       pwm_in,
  input  logic [2:0] hall,
  input  logic       fault_n,
  input  logic       fault_clear,
  output logic [2:0] gate_h,
  output logic [2:0] gate_l,
  output logic [2:0] sector,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int DW = $clog2(DEAD_TIME + 1);

  state_t        state, state_nx;
  logic [1:0]    code_nx;
  logic [DW-1:0] dead_cnt;
  logic [2:0]    pat_h, pat_l;
  logic          drv_dir;
  logic          fn_s1, fn_s2;
  logic          sector_change;
  logic          hall_bad;
  logic          stall_hit;

  hall_filter #(.HALL_FILTER(HALL_FILTER)) u_hall (
    .clk          (clk),
    .reset        (reset),
    .hall         (hall),
    .sector       (sector),
    .sector_change(sector_change)
  );

  // Driver fault synchroniser; resets to the inactive (high) level.
  always_ff @(posedge clk) begin
    if (reset) begin
      fn_s1 <= 1'b1;
      fn_s2 <= 1'b1;
    end else begin
      fn_s1 <= fault_n;
      fn_s2 <= fn_s1;
    end
  end

  assign hall_bad = (sector == SECTOR_NONE) && (state == ST_DEAD || state == ST_DRIVE);

`ifdef STALL_DETECT_EN
  localparam int SW = $clog2(STALL_CYCLES + 1);
  logic [SW-1:0] stall_cnt;

  // Cycles spent in DRIVE since entry or the last sector change.
  always_ff @(posedge clk) begin
    if (reset || state != ST_DRIVE || sector_change)
      stall_cnt <= '0;
    else if (stall_cnt != SW'(STALL_CYCLES))
      stall_cnt <= stall_cnt + SW'(1);
  end

  assign stall_hit = (state == ST_DRIVE) && (stall_cnt == SW'(STALL_CYCLES - 1));
`else
  // No stall counter; the comparison only keeps the shared parameter referenced.
  assign stall_hit = (STALL_CYCLES < 0);
`endif

  // Next state with fault > hall > stall > enable > commutation priority.
  always_comb begin
    state_nx = state;
    code_nx  = FC_NONE;
    case (state)
      ST_FAULT: if (fault_clear && fn_s2) state_nx = ST_IDLE;
      default: begin
        if (!fn_s2) begin
          state_nx = ST_FAULT;
          code_nx  = FC_DRIVER;
        end else if (hall_bad) begin
          state_nx = ST_FAULT;
          code_nx  = FC_HALL;
        end else if (stall_hit) begin
          state_nx = ST_FAULT;
          code_nx  = FC_STALL;
        end else if (state == ST_IDLE) begin
          if (enable && sector != SECTOR_NONE) state_nx = ST_DEAD;
        end else if (!enable) begin
          state_nx = ST_IDLE;
        end else if (state == ST_DEAD) begin
          if (dead_cnt == '0) state_nx = ST_DRIVE;
        end else if (sector_change || dir != drv_dir) begin
          state_nx = ST_DEAD;
        end
      end
    endcase
  end

  // State, dead-time counter, drive pattern latch and fault-code latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dead_cnt   <= '0;
      pat_h      <= '0;
      pat_l      <= '0;
      drv_dir    <= 1'b0;
      fault_code <= FC_NONE;
    end else begin
      state <= state_nx;
      if (state_nx == ST_DEAD && state != ST_DEAD)
        dead_cnt <= DW'(DEAD_TIME - 1);
      else if (state == ST_DEAD && dead_cnt != '0)
        dead_cnt <= dead_cnt - DW'(1);
      if (state == ST_DEAD && state_nx == ST_DRIVE) begin
        {pat_h, pat_l} <= drive_pattern(sector, dir);
        drv_dir        <= dir;
      end else if (state_nx != ST_DRIVE) begin
        pat_h <= '0;
        pat_l <= '0;
      end
      if (state != ST_FAULT && state_nx == ST_FAULT)
        fault_code <= code_nx;
      else if (state == ST_FAULT && state_nx == ST_IDLE)
        fault_code <= FC_NONE;
    end
  end

  assign gate_h = pat_h & {3{pwm_in}};
  assign gate_l = pat_l;
  assign fault  = (fault_code != FC_NONE);

endmodule

// File: tb/tb_bldc_commutator.sv
// Scoreboard bench for bldc_commutator: stimulus tasks predict every change of
// the output bundle {gate_h, gate_l, sector, fault, fault_code} and the cycle
// it should appear; a monitor pops and compares on each observed change.
module tb_bldc_commutator;

  localparam int DT = 4;
  localparam int HF = 5;
  localparam int SC = 100;

  logic       clk = 1'b0;
  logic       reset, enable, dir, pwm_in, fault_n, fault_clear;
  logic [2:0] hall;
  logic [2:0] gate_h, gate_l, sector;
  logic       fault;
  logic [1:0] fault_code;

  bldc_commutator #(.DEAD_TIME(DT), .HALL_FILTER(HF), .STALL_CYCLES(SC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .dir(dir), .pwm_in(pwm_in),
    .hall(hall), .fault_n(fault_n), .fault_clear(fault_clear),
    .gate_h(gate_h), .gate_l(gate_l), .sector(sector), .fault(fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [2:0] gh, gl, sec;
    logic       flt;
    logic [1:0] code;
    int         t;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Reference tables: sector -> hall code {h1,h2,h3}, sector -> phase index
  // (A=0, B=1, C=2) of the forward high / low switch.
  logic [2:0] hall_code [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};
  int         hi_fwd    [6] = '{2, 0, 0, 1, 1, 2};
  int         lo_fwd    [6] = '{1, 1, 2, 2, 0, 0};

  // Model state.
  logic m_drive = 0, m_fault = 0, m_en = 0, m_dir = 1;
  int   m_sec = 7, m_entry = 0;
  logic [1:0] m_code = 0;

  function automatic logic [2:0] bus_of(int s);
    logic [2:0] c;
    c = hall_code[s];
    return {c[0], c[1], c[2]};
  endfunction

  function automatic int sector_of(logic [2:0] b);
    for (int s = 0; s < 6; s++) if (bus_of(s) == b) return s;
    return 7;
  endfunction

  function automatic logic [2:0] ph(int s, logic d);
    return 3'(1 << (d ? hi_fwd[s] : lo_fwd[s]));
  endfunction

  function automatic logic [2:0] pl(int s, logic d);
    return 3'(1 << (d ? lo_fwd[s] : hi_fwd[s]));
  endfunction

  task automatic push(logic [2:0] gh, logic [2:0] gl, int s, logic f, logic [1:0] c, int t);
    ev_t e;
    e.gh = gh; e.gl = gl; e.sec = 3'(s); e.flt = f; e.code = c; e.t = t;
    exp_q.push_back(e);
  endtask

  task automatic go_drive(int t);
    push(ph(m_sec, m_dir), pl(m_sec, m_dir), m_sec, 0, 0, t);
    m_drive = 1;
    m_entry = t;
  endtask

  task automatic tick(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Monitor: any change of the output bundle must match the next prediction.
  logic [11:0] last_snap = 'x;
  logic [11:0] snap;
  always @(negedge clk) begin
    ev_t e;
    snap = {gate_h, gate_l, sector, fault, fault_code};
    if (snap !== last_snap) begin
      last_snap = snap;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change at cycle %0d: got %b", cyc, snap);
      end else begin
        e = exp_q.pop_front();
        if (snap !== {e.gh, e.gl, e.sec, e.flt, e.code}) begin
          errors++;
          $display("FAIL outputs at cycle %0d: got gh=%b gl=%b sec=%0d flt=%b code=%0d, expected gh=%b gl=%b sec=%0d flt=%b code=%0d",
                   cyc, gate_h, gate_l, sector, fault, fault_code, e.gh, e.gl, e.sec, e.flt, e.code);
        end
        if (e.t >= 0) begin
          checks++;
          if (cyc != e.t) begin
            errors++;
            $display("FAIL change_time: got cycle %0d, expected cycle %0d", cyc, e.t);
          end
        end
      end
    end
  end

  task automatic hall_step(logic [2:0] b);
    int n, t1, s;
    tick(1);
    n = cyc;
    hall = b;
    s = sector_of(b);
    t1 = n + HF + 3;
    if (s != m_sec) begin
      if (m_drive) begin
        push(ph(m_sec, m_dir), pl(m_sec, m_dir), s, 0, 0, t1);
        m_sec = s;
        if (s == 7) begin
          push(0, 0, 7, 1, 2, t1 + 1);
          m_drive = 0; m_fault = 1; m_code = 2;
        end else begin
          push(0, 0, s, 0, 0, t1 + 1);
          go_drive(t1 + 1 + DT);
        end
      end else if (m_fault) begin
        m_sec = s;
        push(0, 0, s, 1, m_code, t1);
      end else begin
        m_sec = s;
        push(0, 0, s, 0, 0, t1);
        if (s != 7 && m_en) go_drive(t1 + 1 + DT);
      end
    end
    tick(HF + DT + 8);
  endtask

  task automatic glitch(int len);
    logic [2:0] keep, g;
    keep = hall;
    g = 3'($urandom_range(0, 7));
    if (g == keep) g = ~keep;
    tick(1);
    hall = g;
    tick(len);
    hall = keep;
    tick(HF + 6);
  endtask

  task automatic dir_toggle();
    int n;
    tick(1);
    n = cyc;
    dir = ~dir;
    m_dir = dir;
    if (m_drive) begin
      push(0, 0, m_sec, 0, 0, n + 1);
      go_drive(n + 1 + DT);
    end
    tick(DT + 4);
  endtask

  task automatic enable_cycle();
    int n;
    tick(1);
    n = cyc;
    enable = 0;
    m_en = 0;
    if (m_drive) push(0, 0, m_sec, 0, 0, n + 1);
    m_drive = 0;
    tick(3);
    n = cyc;
    enable = 1;
    m_en = 1;
    if (!m_fault && m_sec != 7) go_drive(n + 1 + DT);
    tick(DT + 4);
  endtask

  task automatic pwm_pulse(int len);
    int n;
    tick(1);
    n = cyc;
    pwm_in = 0;
    if (m_drive) push(0, pl(m_sec, m_dir), m_sec, 0, 0, n);
    tick(len);
    pwm_in = 1;
    if (m_drive) go_drive_restore(n + len);
    tick(2);
  endtask

  task automatic go_drive_restore(int t);
    push(ph(m_sec, m_dir), pl(m_sec, m_dir), m_sec, 0, 0, t);
  endtask

  task automatic fault_assert();
    int n;
    tick(1);
    n = cyc;
    fault_n = 0;
    if (!m_fault) begin
      push(0, 0, m_sec, 1, 1, n + 3);
      m_fault = 1; m_drive = 0; m_code = 1;
    end
    tick(5);
  endtask

  task automatic clear_pulse();
    int n;
    tick(1);
    n = cyc;
    fault_clear = 1;
    if (m_fault && fault_n) begin
      push(0, 0, m_sec, 0, 0, n + 1);
      m_fault = 0; m_code = 0;
      if (m_en && m_sec != 7) go_drive(n + 2 + DT);
    end
    tick(1);
    fault_clear = 0;
    tick(DT + 5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    reset = 1; enable = 0; dir = 1; pwm_in = 1; hall = 3'b000;
    fault_n = 1; fault_clear = 0;
    push(0, 0, 7, 0, 0, -1);
    tick(3);
    reset = 0;
    tick(1);
    enable = 1;
    m_en = 1;

    // Forward rotation through all six codes.
    for (int k = 0; k < 6; k++) hall_step(bus_of(k));

    // Short glitches never change sector or gates.
    glitch(HF - 1);
    glitch(1);

    // Direction change at sector 2.
    hall_step(bus_of(2));
    dir_toggle();
    dir_toggle();

    // Driver fault; clear ignored while fault_n low; release then clear.
    fault_assert();
    clear_pulse();
    tick(1);
    fault_n = 1;
    tick(4);
    clear_pulse();

    // Invalid hall code in DRIVE, then recover.
    hall_step(3'b111);
    hall_step(bus_of(4));
    clear_pulse();

    // Randomised operation.
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 3))
        0: glitch($urandom_range(1, HF - 1));
        1: pwm_pulse($urandom_range(1, 4));
        2: dir_toggle();
        default: enable_cycle();
      endcase
      do s = $urandom_range(0, 5); while (s == m_sec);
      hall_step(bus_of(s));
    end

    // Hold hall static in DRIVE.
    do s = $urandom_range(0, 5); while (s == m_sec);
    hall_step(bus_of(s));
`ifdef STALL_DETECT_EN
    push(0, 0, m_sec, 1, 3, m_entry + SC);
    m_drive = 0; m_fault = 1; m_code = 3;
    tick(SC + 10);
`else
    tick(2 * SC);
`endif

    // Reset mid-operation forces everything off on the next edge.
    tick(1);
    reset = 1; enable = 0; hall = 3'b000;
    push(0, 0, 7, 0, 0, cyc + 1);
    tick(3);
    reset = 0;
    tick(20);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
